// File: rtl/deser_pkg.sv
// Shared types and constants for the shift_deserializer serial receiver.
package deser_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StParity
    } deser_state_e;

    localparam int unsigned DESER_WIDTH = 16;

    // Leaves headroom above WIDTH so the counter can sit at WIDTH in the parity state.
    function automatic int unsigned deser_cnt_width(input int unsigned width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/deser_out_buf.sv
// One-word holding buffer with valid/ready handshake and sticky overrun flag.
module deser_out_buf #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             perr_i,
    input  logic             out_ready_i,
    input  logic             clr_ovr_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             perr_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             ovr_q, ovr_d;
    logic             accept;
    logic             drop;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ovr_d   = ovr_q;
        // A word may load into the slot being drained on this same edge.
        accept  = load_i && (!valid_q || out_ready_i);
        drop    = load_i && !accept;

        if (accept) begin
            data_d  = word_i;
            perr_d  = perr_i;
            valid_d = 1'b1;
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end

        if (drop) begin
            ovr_d = 1'b1;
        end else if (clr_ovr_i) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign perr_o    = perr_q;
    assign overrun_o = ovr_q;

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver with selectable bit order and a one-word output buffer.
// Define DESER_PARITY_EN to expect an even-parity bit after every word.
module shift_deserializer
    import deser_pkg::*;
#(
    parameter int unsigned WIDTH = DESER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ser_in,
    input  logic             dir,
    input  logic             sync,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    input  logic             clr_ovr,
    output logic             parity_err
);

    localparam int unsigned CntW = deser_cnt_width(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    deser_state_e     state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic             load;
    logic             perr;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        load    = 1'b0;
        word    = shreg_q;
        perr    = 1'b0;
        shifted = dir_q ? {shreg_q[WIDTH-2:0], ser_in} : {ser_in, shreg_q[WIDTH-1:1]};

        if (en) begin
            if (sync || state_q == StIdle) begin
                // First bit lands where a full run of shifts will carry it to its final slot.
                dir_d   = dir;
                cnt_d   = CntW'(1);
                state_d = StShift;
                shreg_d = dir ? {{(WIDTH-1){1'b0}}, ser_in} : {ser_in, {(WIDTH-1){1'b0}}};
            end else if (state_q == StShift) begin
                shreg_d = shifted;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
`ifdef DESER_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StIdle;
                    cnt_d   = '0;
                    load    = 1'b1;
                    word    = shifted;
`endif
                end
            end
`ifdef DESER_PARITY_EN
            else begin
                state_d = StIdle;
                cnt_d   = '0;
                load    = 1'b1;
                word    = shreg_q;
                perr    = (^shreg_q) ^ ser_in;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    deser_out_buf #(
        .WIDTH(WIDTH)
    ) u_out_buf (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .word_i     (word),
        .perr_i     (perr),
        .out_ready_i(out_ready),
        .clr_ovr_i  (clr_ovr),
        .data_o     (data_out),
        .valid_o    (out_valid),
        .perr_o     (parity_err),
        .overrun_o  (overrun)
    );

endmodule

// File: tb/tb_shift_deserializer.sv
// Self-checking bench for shift_deserializer: directed scenarios plus randomized words.
module tb_shift_deserializer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         ser_in;
    logic         dir;
    logic         sync;
    logic [W-1:0] data_out;
    logic         out_valid;
    logic         out_ready;
    logic         overrun;
    logic         clr_ovr;
    logic         parity_err;

    int checks   = 0;
    int failures = 0;

    shift_deserializer #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .ser_in    (ser_in),
        .dir       (dir),
        .sync      (sync),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .clr_ovr   (clr_ovr),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic send_bit(input logic b, input logic d, input logic s);
        en     = 1'b1;
        ser_in = b;
        dir    = d;
        sync   = s;
        @(posedge clk);
        #1;
        en   = 1'b0;
        sync = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bit order comes from the first bit's dir; later dir values are random noise.
    task automatic send_data_bits(input logic [W-1:0] v, input logic d, input logic s,
                                  input int gap_max);
        for (int i = 0; i < W; i++) begin
            logic b;
            logic dd;
            b  = d ? v[W-1-i] : v[i];
            dd = (i == 0) ? d : logic'($urandom_range(0, 1));
            send_bit(b, dd, (i == 0) ? s : 1'b0);
            if (i < W - 1 && gap_max > 0) idle($urandom_range(0, gap_max));
        end
    endtask

    task automatic send_word(input logic [W-1:0] v, input logic d, input logic s,
                             input int gap_max);
        send_data_bits(v, d, s, gap_max);
`ifdef DESER_PARITY_EN
        send_bit(^v, 1'b0, 1'b0);
`endif
    endtask

    task automatic test_reset();
        checks++;
        if (data_out !== '0 || out_valid !== 1'b0 || overrun !== 1'b0 || parity_err !== 1'b0) begin
            failures++;
            $display("FAIL reset: data=%h valid=%b ovr=%b perr=%b, want all 0",
                     data_out, out_valid, overrun, parity_err);
        end
    endtask

    task automatic test_msb_first();
        out_ready = 1'b1;
        send_word(16'hA5C3, 1'b1, 1'b0, 0);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 16'hA5C3) begin
            failures++;
            $display("FAIL msb_first: valid=%b data=%h, want 1 a5c3", out_valid, data_out);
        end
        idle(1);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL msb_valid_pulse: valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_lsb_first_gaps();
        logic [W-1:0] v;
        v = 16'hA5C3;
        for (int i = 0; i < W; i++) begin
            // dir toggles on every bit; only the first bit's value (0) matters.
            send_bit(v[i], logic'(i % 2), 1'b0);
            if (i == 4 || i == 11) idle(3);
            if (i == W - 2) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL lsb_early_valid: valid=%b, want 0", out_valid);
                end
            end
        end
`ifdef DESER_PARITY_EN
        send_bit(^v, 1'b0, 1'b0);
`endif
        checks++;
        if (out_valid !== 1'b1 || data_out !== 16'hA5C3) begin
            failures++;
            $display("FAIL lsb_first: valid=%b data=%h, want 1 a5c3", out_valid, data_out);
        end
        idle(1);
    endtask

    task automatic test_overrun();
        out_ready = 1'b0;
        send_word(16'h1234, 1'b1, 1'b0, 0);
        send_word(16'hBEEF, 1'b1, 1'b0, 0);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 16'h1234 || overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set: valid=%b data=%h ovr=%b, want 1 1234 1",
                     out_valid, data_out, overrun);
        end
        idle(2);
        checks++;
        if (data_out !== 16'h1234 || overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_hold: data=%h ovr=%b, want 1234 1", data_out, overrun);
        end
        out_ready = 1'b1;
        clr_ovr   = 1'b1;
        idle(1);
        clr_ovr = 1'b0;
        checks++;
        if (overrun !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clear: ovr=%b valid=%b, want 0 0", overrun, out_valid);
        end
    endtask

    task automatic test_sync();
        for (int i = 0; i < 7; i++) send_bit(logic'($urandom_range(0, 1)), 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL sync_pre: valid=%b, want 0", out_valid);
        end
        send_word(16'h00FF, 1'b1, 1'b1, 0);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 16'h00FF) begin
            failures++;
            $display("FAIL sync_word: valid=%b data=%h, want 1 00ff", out_valid, data_out);
        end
        idle(1);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL sync_single: valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_word();
        for (int i = 0; i < 9; i++) send_bit(logic'($urandom_range(0, 1)), 1'b1, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        test_reset();
        send_word(16'h8001, 1'b1, 1'b0, 0);
        checks++;
        if (out_valid !== 1'b1 || data_out !== 16'h8001) begin
            failures++;
            $display("FAIL reset_mid_word: valid=%b data=%h, want 1 8001", out_valid, data_out);
        end
        idle(1);
    endtask

    task automatic test_random_words();
        out_ready = 1'b1;
        for (int n = 0; n < 24; n++) begin
            logic [W-1:0] v;
            logic         d;
            v = W'($urandom);
            d = logic'($urandom_range(0, 1));
            send_word(v, d, 1'b0, 2);
            checks++;
            if (out_valid !== 1'b1 || data_out !== v || parity_err !== 1'b0) begin
                failures++;
                $display("FAIL random_word %0d: valid=%b data=%h perr=%b, want 1 %h 0",
                         n, out_valid, data_out, parity_err, v);
            end
            idle($urandom_range(1, 3));
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            logic [W-1:0] v;
            logic         d;
            v = W'($urandom);
            d = logic'($urandom_range(0, 1));
            send_word(v, d, 1'b0, 0);
            checks++;
            if (out_valid !== 1'b1 || data_out !== v || overrun !== 1'b0) begin
                failures++;
                $display("FAIL back_to_back %0d: valid=%b data=%h ovr=%b, want 1 %h 0",
                         n, out_valid, data_out, overrun, v);
            end
        end
        idle(1);
    endtask

`ifdef DESER_PARITY_EN
    task automatic test_parity();
        logic [W-1:0] words [2];
        logic         want  [2];
        words[0] = 16'h0003;
        want[0]  = 1'b0;
        words[1] = 16'h0007;
        want[1]  = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            send_data_bits(words[n], 1'b1, 1'b0, 0);
            send_bit(1'b0, 1'b0, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || data_out !== words[n] || parity_err !== want[n]) begin
                failures++;
                $display("FAIL parity %0d: valid=%b data=%h perr=%b, want 1 %h %b",
                         n, out_valid, data_out, parity_err, words[n], want[n]);
            end
        end
        idle(1);
    endtask
`endif

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        ser_in    = 1'b0;
        dir       = 1'b0;
        sync      = 1'b0;
        out_ready = 1'b0;
        clr_ovr   = 1'b0;
        idle(2);
        rst = 1'b0;
        test_reset();
        test_msb_first();
        test_lsb_first_gaps();
        test_overrun();
        test_sync();
        test_reset_mid_word();
        test_random_words();
        test_back_to_back();
`ifdef DESER_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_deserializer.md
# shift_deserializer

Serial-to-parallel receiver that rebuilds WIDTH-bit words from a one-bit stream produced by the team's shift register datapath, with selectable MSB-first/LSB-first bit order. It sits at the receiving end of the serial link. It presents completed words on a valid/ready output port through a one-word holding buffer, so collection of the next word continues while the consumer drains the current one.

## Interface
- WIDTH, 16, word width in bits (≥2)
- clk  in  1  rising-edge clock; the block's only clock
- rst  in  1  reset; synchronous and active-high
- en  in  1  serial bit valid; ser_in is sampled on each rising edge where en=1
- ser_in  in  1  serial data bit
- dir  in  1  bit order; 1 = MSB first, 0 = LSB first; sampled only with a word's first bit
- sync  in  1  with en=1, forces the sampled bit to be bit 0 of a new word and discards any partial word
- data_out  out  WIDTH  completed word; stable while out_valid=1
- out_valid  out  1  data_out holds an unconsumed word
- out_ready  in  1  consumer accepts data_out
- overrun  out  1  sticky; a completed word was dropped
- clr_ovr  in  1  clears overrun
- parity_err  out  1  parity mismatch on the word in data_out; qualified by out_valid

## Operation
- States: IDLE (no partial word), SHIFT (collecting data bits), PARITY (waiting for the parity bit; only with DESER_PARITY_EN).
- IDLE + en: load the first bit, latch dir into dir_q, set bit count to 1, and go to SHIFT.
- SHIFT + en, dir_q=1: shift register left, with ser_in entering at the LSB.
- SHIFT + en, dir_q=0: shift register right, with ser_in entering at the MSB.
- SHIFT with count reaching WIDTH: the word is complete. Go to PARITY if enabled, else go to IDLE and present the word.
- en=0: hold all state. Idle gaps are allowed anywhere inside a word.
- sync+en, in any state: the bit becomes bit 0 of a new word, dir is re-latched, the partial word is discarded, and overrun is unchanged.
- Presenting a completed word:
  - Holding buffer empty, or draining on the same edge (out_valid && out_ready): the word is loaded and out_valid=1 on the next cycle.
  - Otherwise: the word is dropped, overrun is set, and data_out is unchanged.
- overrun is cleared by clr_ovr. If clr_ovr and a new drop occur on the same edge, set wins.
- Reset values: data_out=0, out_valid=0, overrun=0, parity_err=0, state IDLE, count 0, dir_q=0.
- rst asserted mid-word discards the partial word and clears the holding buffer.

## Timing
- Word latency: out_valid rises on the cycle after the edge that samples the final bit (data bit WIDTH-1, or the parity bit).
- Handshake: a transfer occurs on an edge where out_valid && out_ready.
  - out_valid falls on the next cycle unless a new word loads on that same edge.
  - Back-to-back words at one bit per cycle sustain full throughput when out_ready=1.
- data_out and parity_err must not change while out_valid=1 and out_ready=0.
- Minimum word time is WIDTH cycles (WIDTH+1 with parity). No dead cycle is required between words.

## Configuration
- DESER_PARITY_EN defined:
  - One extra bit follows every word, giving even parity over the data bits plus the parity bit.
  - parity_err=1 when the XOR over those WIDTH+1 bits is 1.
  - sync during PARITY restarts the word as specified under Operation.
- DESER_PARITY_EN undefined:
  - The PARITY state is not built.
  - parity_err is tied to 0. The port list is identical in both builds.

## Structure
- Package deser_pkg:
  - state enum (IDLE, SHIFT, PARITY)
  - default width constant DESER_WIDTH=16
  - count width as a function of WIDTH: $clog2(WIDTH+2)
- Sub-module deser_out_buf: the holding register plus valid/ready/overrun logic, parameterized by WIDTH. It accepts a load strobe and the word from the top level.

## Test plan
- MSB first: dir=1, out_ready=1, 16 bits of 0xA5C3 on consecutive cycles → data_out=0xA5C3 and out_valid=1 for one cycle, 1 cycle after the last bit.
- LSB first: dir=0, bits of 0xA5C3 sent LSB first, with en=0 gaps of 3 cycles inserted after bits 4 and 11 → data_out=0xA5C3. Toggling dir mid-word has no effect.
- Overrun:
  - out_ready=0, send 0x1234 then 0xBEEF → data_out stays 0x1234 and overrun=1.
  - Then raise out_ready and pulse clr_ovr → overrun=0.
- sync mid-word: after 7 bits, assert sync+en and send a full 0x00FF → exactly one word, 0x00FF.
- Reset mid-word: rst for 1 cycle after 9 bits → all outputs 0. The following 16 bits of 0x8001 produce 0x8001.
- DESER_PARITY_EN build:
  - 0x0003 with parity bit 0 → parity_err=0.
  - 0x0007 with parity bit 0 → parity_err=1.
  - Both words arrive on out_valid cycles.
